// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 run-control slice.
// Contents: run-state enum, PC width and the default timing parameters.
package td4_pkg;

  localparam int unsigned TD4_PC_W                = 4;
  localparam int unsigned RUN_DIV_DEFAULT         = 12_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 240_000;

  typedef enum logic [1:0] {
    StHalt = 2'd0,
    StStep = 2'd1,
    StRun  = 2'd2,
    StBrk  = 2'd3
  } run_state_e;

endpackage

// File: rtl/td4_debounce.sv
// Button conditioner: 2-flop synchronizer followed by a stable-level debouncer.
// Ports:
//   CLK   - system clock
//   RST   - synchronous active-low reset
//   raw   - asynchronous, bouncy button input (active-high)
//   level - debounced button level
//   press - one-cycle pulse on a 0->1 change of level (nothing on release)
module td4_debounce
  import td4_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync_q <= 2'b00;
      cnt_q  <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      press  <= 1'b0;
      if (sync_q[1] == level) begin
        // Any agreement restarts the stability window.
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        level <= sync_q[1];
        press <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/td4_run_ctrl.sv
// Run-control sequencer for the TD4 4-bit CPU. Produces the one-cycle step_en
// strobe that enables every CPU register update.
// Ports:
//   CLK, RST   - system clock, synchronous active-low reset
//   btn_step   - raw single-step button
//   btn_run    - raw run/halt toggle button
//   bp_en      - breakpoint enable
//   bp_addr    - breakpoint PC value
//   pc         - current CPU program counter (feedback from the core)
//   step_en    - registered, high one cycle per instruction
//   running    - high while in RUN
//   bp_hit     - high while stopped at a breakpoint
//   step_count - issued steps, modulo 256
module td4_run_ctrl
  import td4_pkg::*;
#(
  parameter int unsigned RUN_DIV         = RUN_DIV_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                btn_step,
  input  logic                btn_run,
  input  logic                bp_en,
  input  logic [TD4_PC_W-1:0] bp_addr,
  input  logic [TD4_PC_W-1:0] pc,
  output logic                step_en,
  output logic                running,
  output logic                bp_hit,
  output logic [7:0]          step_count
);

  localparam int unsigned DivW = $clog2(RUN_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(RUN_DIV - 1);

  logic step_evt, run_evt;
  logic step_level, run_level;
  logic unused_level;

  run_state_e      state_q;
  logic [DivW-1:0] div_q;
  logic            bp_skip_q;

  td4_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_step (
    .CLK  (CLK),
    .RST  (RST),
    .raw  (btn_step),
    .level(step_level),
    .press(step_evt)
  );

  td4_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_run (
    .CLK  (CLK),
    .RST  (RST),
    .raw  (btn_run),
    .level(run_level),
    .press(run_evt)
  );

  // Only the press events drive the sequencer.
  assign unused_level = step_level ^ run_level;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= StHalt;
      step_en    <= 1'b0;
      running    <= 1'b0;
      bp_hit     <= 1'b0;
      step_count <= 8'd0;
      div_q      <= '0;
      bp_skip_q  <= 1'b0;
    end else begin
      step_en <= 1'b0;
      unique case (state_q)
        StHalt, StBrk: begin
          // run_evt has priority; a simultaneous step_evt is dropped.
          if (run_evt) begin
            state_q   <= StRun;
            div_q     <= '0;
            bp_skip_q <= 1'b1;
            running   <= 1'b1;
            bp_hit    <= 1'b0;
          end else if (step_evt) begin
            state_q    <= StStep;
            step_en    <= 1'b1;
            step_count <= step_count + 8'd1;
            bp_hit     <= 1'b0;
          end
        end
        StStep: begin
          state_q <= StHalt;
        end
        StRun: begin
          if (run_evt) begin
            state_q <= StHalt;
            div_q   <= '0;
            running <= 1'b0;
          end else if (div_q == DivLast) begin
            div_q <= '0;
            // bp_skip lets a resume execute the instruction it stopped on.
            if (bp_en && (pc == bp_addr) && !bp_skip_q) begin
              state_q <= StBrk;
              running <= 1'b0;
              bp_hit  <= 1'b1;
            end else begin
              step_en    <= 1'b1;
              step_count <= step_count + 8'd1;
              bp_skip_q  <= 1'b0;
            end
          end else begin
            div_q <= div_q + DivW'(1);
          end
        end
        default: begin
          state_q <= StHalt;
          running <= 1'b0;
          bp_hit  <= 1'b0;
        end
      endcase
    end
  end

endmodule
